// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP adder scheduler.
package fpu_pkg;

  // Scheduler FSM: wait for a request, strobe the adder, hold the result.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } state_t;

  // IEEE-754 single-precision word width.
  localparam int FP_W = 32;

  // Requester identifiers carried on resp_id.
  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from two valids, pointer moves on update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant
);

  // prio_r = 1 means port 1 wins a tie, 0 means port 0 wins.
  logic prio_r;

  // Grant selection: a lone valid always wins, a tie goes to the favoured port.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_r ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer update: after a granted transfer, favour the other port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= 1'b0;
    end else if (update) begin
      prio_r <= grant[0];
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/fpu_add_scheduler.sv
// Shares one external combinational FP adder between two requesters,
// returning results on a single response channel tagged with the requester id.
module fpu_add_scheduler
  import fpu_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int FP_W  = fpu_pkg::FP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [FP_W-1:0]  req0_data1,
  input  logic [FP_W-1:0]  req0_data2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [FP_W-1:0]  req1_data1,
  input  logic [FP_W-1:0]  req1_data2,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [FP_W-1:0]  resp_data,
  output logic             resp_id,
  output logic             resp_ok,
  output logic [FP_W-1:0]  add_data1,
  output logic [FP_W-1:0]  add_data2,
  output logic             add_in_valid,
  input  logic [FP_W-1:0]  add_data_out,
  input  logic             add_out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t            state_r;
  state_t            state_nx_s;
  logic [1:0]        grant_s;
  logic              hs0_s;
  logic              hs1_s;
  logic              hs_s;
  logic [FP_W-1:0]   op1_r;
  logic [FP_W-1:0]   op2_r;
  logic              id_r;
  logic [FP_W-1:0]   resp_data_r;
  logic              resp_ok_r;
  logic              resp_valid_r;
  logic              add_in_valid_r;
  logic              busy_r;
  logic [CNT_W-1:0]  op_count_r;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .update (hs_s),
    .grant  (grant_s)
  );

  assign req0_ready = (state_r == IDLE) && grant_s[0];
  assign req1_ready = (state_r == IDLE) && grant_s[1];
  assign hs0_s      = req0_valid && req0_ready;
  assign hs1_s      = req1_valid && req1_ready;
  assign hs_s       = hs0_s || hs1_s;

  assign add_data1    = op1_r;
  assign add_data2    = op2_r;
  assign add_in_valid = add_in_valid_r;
  assign resp_valid   = resp_valid_r;
  assign resp_data    = resp_data_r;
  assign resp_id      = id_r;
  assign resp_ok      = resp_ok_r;
  assign busy         = busy_r;
  assign op_count     = op_count_r;

  // Next-state logic: EXEC is a single cycle, HOLD waits for the consumer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) state_nx_s = EXEC;
        else      state_nx_s = IDLE;
      end
      EXEC: state_nx_s = HOLD;
      HOLD: begin
        if (resp_ready) state_nx_s = IDLE;
        else            state_nx_s = HOLD;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      resp_valid_r   <= 1'b0;
      add_in_valid_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      resp_valid_r   <= (state_nx_s == HOLD);
      add_in_valid_r <= (state_nx_s == EXEC);
      busy_r         <= (state_nx_s != IDLE);
    end
  end

  // Operand capture: only a handshake loads operands and requester id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_r <= {FP_W{1'b0}};
      op2_r <= {FP_W{1'b0}};
      id_r  <= REQ_ID0;
    end else if (hs0_s) begin
      op1_r <= req0_data1;
      op2_r <= req0_data2;
      id_r  <= REQ_ID0;
    end else if (hs1_s) begin
      op1_r <= req1_data1;
      op2_r <= req1_data2;
      id_r  <= REQ_ID1;
    end else begin
      op1_r <= op1_r;
      op2_r <= op2_r;
      id_r  <= id_r;
    end
  end

  // Result capture in EXEC; the value then stays frozen through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data_r <= {FP_W{1'b0}};
      resp_ok_r   <= 1'b0;
    end else if (state_r == EXEC) begin
      resp_data_r <= add_data_out;
      resp_ok_r   <= add_out_valid;
    end else begin
      resp_data_r <= resp_data_r;
      resp_ok_r   <= resp_ok_r;
    end
  end

  // Completed-response counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= {CNT_W{1'b0}};
    end else if ((state_r == HOLD) && resp_ready) begin
      op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      op_count_r <= op_count_r;
    end
  end

endmodule

// File: tb/tb_fpu_add_scheduler.sv
// Directed bench for fpu_add_scheduler with a table-driven external adder model.
module tb_fpu_add_scheduler;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_data1, req0_data2;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_data1, req1_data2;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_id, resp_ok;
  logic [31:0] add_data1, add_data2;
  logic        add_in_valid;
  logic [31:0] add_data_out;
  logic        add_out_valid;
  logic        busy;
  logic [1:0]  op_count;

  int checks = 0;
  int errors = 0;

  fpu_add_scheduler #(.CNT_W(2), .FP_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data1(req0_data1), .req0_data2(req0_data2),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data1(req1_data1), .req1_data2(req1_data2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_ok(resp_ok),
    .add_data1(add_data1), .add_data2(add_data2), .add_in_valid(add_in_valid),
    .add_data_out(add_data_out), .add_out_valid(add_out_valid),
    .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder: hand-computed sums for the operand pairs used here.
  always_comb begin
    add_data_out  = 32'hDEAD_BEEF;
    add_out_valid = 1'b0;
    case ({add_data1, add_data2})
      {32'h3F80_0000, 32'h4000_0000}: begin add_data_out = 32'h4040_0000; add_out_valid = 1'b1; end
      {32'h0000_0000, 32'h40A0_0000}: begin add_data_out = 32'h40A0_0000; add_out_valid = 1'b1; end
      {32'h7F80_0000, 32'h3F80_0000}: begin add_data_out = 32'h7F80_0000; add_out_valid = 1'b0; end
      default: begin add_data_out = 32'hDEAD_BEEF; add_out_valid = 1'b0; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        exp_id;
    logic [1:0]  exp_cnt;

    rst_n = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_data1 = 32'h0; req0_data2 = 32'h0;
    req1_valid = 1'b0; req1_data1 = 32'h0; req1_data2 = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_add_in_valid", 32'(add_in_valid), 32'd0);
    chk("rst_add_data1", add_data1, 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_ok", 32'(resp_ok), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // req0: 1.0 + 2.0, consumer always ready
    req0_valid = 1'b1; req0_data1 = 32'h3F80_0000; req0_data2 = 32'h4000_0000; resp_ready = 1'b1;
    #1;
    chk("t1_req0_ready", 32'(req0_ready), 32'd1);
    chk("t1_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req0_data1 = 32'h1234_5678; req0_data2 = 32'h1234_5678;
    chk("t1_exec_busy", 32'(busy), 32'd1);
    chk("t1_exec_add_in_valid", 32'(add_in_valid), 32'd1);
    chk("t1_exec_add_data1", add_data1, 32'h3F80_0000);
    chk("t1_exec_add_data2", add_data2, 32'h4000_0000);
    chk("t1_exec_resp_valid", 32'(resp_valid), 32'd0);
    chk("t1_exec_req0_ready", 32'(req0_ready), 32'd0);
    @(negedge clk);
    chk("t1_hold_resp_valid", 32'(resp_valid), 32'd1);
    chk("t1_hold_resp_data", resp_data, 32'h4040_0000);
    chk("t1_hold_resp_id", 32'(resp_id), 32'd0);
    chk("t1_hold_resp_ok", 32'(resp_ok), 32'd1);
    chk("t1_hold_add_in_valid", 32'(add_in_valid), 32'd0);
    @(negedge clk);
    chk("t1_done_resp_valid", 32'(resp_valid), 32'd0);
    chk("t1_done_busy", 32'(busy), 32'd0);
    chk("t1_done_op_count", 32'(op_count), 32'd1);

    // req1: 0.0 + 5.0, then consumer stalls 5 cycles in HOLD
    req1_valid = 1'b1; req1_data1 = 32'h0000_0000; req1_data2 = 32'h40A0_0000; resp_ready = 1'b0;
    #1;
    chk("t2_req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_stall_resp_valid", 32'(resp_valid), 32'd1);
      chk("t2_stall_resp_data", resp_data, 32'h40A0_0000);
      chk("t2_stall_resp_id", 32'(resp_id), 32'd1);
      chk("t2_stall_resp_ok", 32'(resp_ok), 32'd1);
      chk("t2_stall_ready0", 32'(req0_ready), 32'd0);
      chk("t2_stall_ready1", 32'(req1_ready), 32'd0);
      chk("t2_stall_op_count", 32'(op_count), 32'd1);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    chk("t2_done_op_count", 32'(op_count), 32'd2);
    chk("t2_done_resp_valid", 32'(resp_valid), 32'd0);

    // Inf + 1.0: adder flags invalid, response still delivered
    req0_valid = 1'b1; req0_data1 = 32'h7F80_0000; req0_data2 = 32'h3F80_0000;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t3_resp_valid", 32'(resp_valid), 32'd1);
    chk("t3_resp_data", resp_data, 32'h7F80_0000);
    chk("t3_resp_ok", 32'(resp_ok), 32'd0);
    @(negedge clk);
    chk("t3_op_count", 32'(op_count), 32'd3);

    // Reset pulse while a req0 operation is in EXEC
    req0_valid = 1'b1; req0_data1 = 32'h3F80_0000; req0_data2 = 32'h4000_0000;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("t4_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("t4_rst_op_count", 32'(op_count), 32'd0);
    chk("t4_rst_add_in_valid", 32'(add_in_valid), 32'd0);
    chk("t4_rst_add_data1", add_data1, 32'h0);
    @(negedge clk);
    chk("t4_rst_hold_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t4_after_resp_valid", 32'(resp_valid), 32'd0);
      chk("t4_after_busy", 32'(busy), 32'd0);
    end

    // Both ports valid continuously: alternating grants, counter wraps
    req0_valid = 1'b1; req0_data1 = 32'h3F80_0000; req0_data2 = 32'h4000_0000;
    req1_valid = 1'b1; req1_data1 = 32'h0000_0000; req1_data2 = 32'h40A0_0000;
    resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_id  = (k % 2) == 1;
      exp_cnt = 2'((k + 1) % 4);
      chk("rr_ready0", 32'(req0_ready), 32'(!exp_id));
      chk("rr_ready1", 32'(req1_ready), 32'(exp_id));
      @(negedge clk);
      chk("rr_exec_add_in_valid", 32'(add_in_valid), 32'd1);
      @(negedge clk);
      chk("rr_resp_valid", 32'(resp_valid), 32'd1);
      chk("rr_resp_id", 32'(resp_id), 32'(exp_id));
      chk("rr_resp_data", resp_data, exp_id ? 32'h40A0_0000 : 32'h4040_0000);
      @(negedge clk);
      #1;
      chk("rr_op_count", 32'(op_count), 32'(exp_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
